// File: rtl/change_dispenser.sv
// change_dispenser: turns each vend command into a timed cup pulse followed by one pulse per change coin.
// Define COIN_INVENTORY_EN to track coin stock and substitute smaller coins when a denomination runs out.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned INIT_COINS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cafe,
  input  logic       t50,
  input  logic       t100,
  input  logic       t200,
  input  logic       refill,
  output logic       cup_o,
  output logic       coin50_o,
  output logic       coin100_o,
  output logic       coin200_o,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CUP = 3'd1, GAP = 3'd2, SELECT = 3'd3, PAY = 3'd4, DONE = 3'd5
  } state_t;

  state_t      state;
  logic        cafe_q;
  logic [2:0]  p50, p100, p200;
  logic [31:0] cnt;
  logic        pulse_end, gap_end;

  assign pulse_end = (cnt == 32'(PULSE_CYCLES - 1));
  assign gap_end   = (cnt == 32'(GAP_CYCLES - 1));
  assign state_o   = state;

`ifdef COIN_INVENTORY_EN
  localparam logic [7:0] INIT8 = 8'(INIT_COINS);
  logic [7:0] inv50, inv100, inv200;
`else
  logic unused_cfg;
  assign unused_cfg = refill ^ (INIT_COINS != 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cafe_q    <= 1'b0;
      cnt       <= '0;
      p50       <= '0;
      p100      <= '0;
      p200      <= '0;
      cup_o     <= 1'b0;
      coin50_o  <= 1'b0;
      coin100_o <= 1'b0;
      coin200_o <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef COIN_INVENTORY_EN
      err       <= 1'b0;
      inv50     <= INIT8;
      inv100    <= INIT8;
      inv200    <= INIT8;
`endif
    end else begin
      cafe_q <= cafe;
      done   <= 1'b0;
      cnt    <= cnt + 32'd1;
      case (state)
        IDLE: begin
          if (cafe && !cafe_q) begin
            p50   <= {2'b00, t50};
            p100  <= {2'b00, t100};
            p200  <= {2'b00, t200};
            cup_o <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= CUP;
`ifdef COIN_INVENTORY_EN
            err   <= 1'b0;
`endif
          end
`ifdef COIN_INVENTORY_EN
          if (refill) begin
            inv50  <= INIT8;
            inv100 <= INIT8;
            inv200 <= INIT8;
          end
`endif
        end
        CUP: if (pulse_end) begin
          cup_o <= 1'b0;
          cnt   <= '0;
          state <= GAP;
        end
        GAP: if (gap_end) begin
          cnt   <= '0;
          state <= SELECT;
        end
        // Highest denomination first; an empty stock converts one coin per cycle into two smaller ones.
        SELECT: begin
          cnt <= '0;
          if (p200 != 3'd0) begin
`ifdef COIN_INVENTORY_EN
            if (inv200 == 8'd0) begin
              p200 <= p200 - 3'd1;
              p100 <= p100 + 3'd2;
            end else
`endif
            begin
              coin200_o <= 1'b1;
              state     <= PAY;
            end
          end else if (p100 != 3'd0) begin
`ifdef COIN_INVENTORY_EN
            if (inv100 == 8'd0) begin
              p100 <= p100 - 3'd1;
              p50  <= p50 + 3'd2;
            end else
`endif
            begin
              coin100_o <= 1'b1;
              state     <= PAY;
            end
          end else if (p50 != 3'd0) begin
`ifdef COIN_INVENTORY_EN
            if (inv50 == 8'd0) begin
              p50 <= '0;
              err <= 1'b1;
            end else
`endif
            begin
              coin50_o <= 1'b1;
              state    <= PAY;
            end
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        PAY: if (pulse_end) begin
          cnt       <= '0;
          state     <= GAP;
          coin50_o  <= 1'b0;
          coin100_o <= 1'b0;
          coin200_o <= 1'b0;
          if (coin200_o) begin
            p200 <= p200 - 3'd1;
`ifdef COIN_INVENTORY_EN
            inv200 <= inv200 - 8'd1;
`endif
          end else if (coin100_o) begin
            p100 <= p100 - 3'd1;
`ifdef COIN_INVENTORY_EN
            inv100 <= inv100 - 8'd1;
`endif
          end else begin
            p50 <= p50 - 3'd1;
`ifdef COIN_INVENTORY_EN
            inv50 <= inv50 - 8'd1;
`endif
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt       <= '0;
          cup_o     <= 1'b0;
          coin50_o  <= 1'b0;
          coin100_o <= 1'b0;
          coin200_o <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
